counter_sequencer: RTL and testbench



---
 rtl/counter_sequencer.sv | 135 +++++++++++++
 tb/tb_counter_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer that turns a free-running W-bit counter into a modulo-(term+1) counter.
// It supports continuous and one-shot modes.
// Outputs are combinational decodes of the registered state and cnt_q.
// start and halt take effect one cycle after they are sampled.
// Optional feature: define CNT_SEQ_PAUSE_EN to build the PAUSE state.
// Without it, the pause input is ignored.
module counter_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt,
  input  logic         pause,
  input  logic         one_shot,
  input  logic [W-1:0] term,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_en,
  output logic         cnt_clr,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
`ifdef CNT_SEQ_PAUSE_EN
    S_PAUSE,
`endif
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] term_q, term_d;
  logic         one_shot_q, one_shot_d;
  logic         terminal;
  logic         pause_req;

`ifdef CNT_SEQ_PAUSE_EN
  assign pause_req = pause;
`else
  logic pause_unused;
  assign pause_unused = pause;
  assign pause_req    = 1'b0;
`endif

  // The >= compare recovers if something pushed the counter past term.
  assign terminal = (cnt_q >= term_q);

  // State register and the term/mode values latched on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      term_q     <= '0;
      one_shot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      one_shot_q <= one_shot_d;
    end
  end

  // Output decode, then next state. Priority is halt > start > pause > normal.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    one_shot_d = one_shot_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    tc         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_CLEAR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
        // A pause request suppresses the increment in the cycle it is seen.
        if (!pause_req) begin
          if (terminal) begin
            tc      = 1'b1;
            cnt_clr = !one_shot_q;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`ifdef CNT_SEQ_PAUSE_EN
      S_PAUSE: begin
        busy = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase

    if (halt) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d    = S_CLEAR;
      term_d     = term;
      one_shot_d = one_shot;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_CLEAR: state_d = S_RUN;
        S_RUN: begin
`ifdef CNT_SEQ_PAUSE_EN
          if (pause_req) begin
            state_d = S_PAUSE;
          end else
`endif
          if (terminal && one_shot_q) begin
            state_d = S_DONE;
          end
        end
`ifdef CNT_SEQ_PAUSE_EN
        S_PAUSE: begin
          if (!pause_req) state_d = S_RUN;
        end
`endif
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with a behavioural 4-bit counter in the loop.
// Expected per-cycle outputs {q,en,clr,tc,busy,done} are queued as stimulus is scheduled.
// They are popped and compared at each falling edge.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, halt, pause, one_shot;
  logic [3:0] term, cnt_q;
  logic       cnt_en, cnt_clr, tc, busy, done;

  typedef logic [8:0] exp_t;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pause(pause),
    .one_shot(one_shot), .term(term), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .tc(tc), .busy(busy), .done(done)
  );

  // Counter datapath: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (reset)        cnt_q <= 4'd0;
    else if (cnt_clr) cnt_q <= 4'd0;
    else if (cnt_en)  cnt_q <= cnt_q + 4'd1;
  end

  task automatic check(input string tag, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got q=%0d en=%b clr=%b tc=%b busy=%b done=%b, want q=%0d en=%b clr=%b tc=%b busy=%b done=%b",
               tag, got[8:5], got[4], got[3], got[2], got[1], got[0],
               want[8:5], want[4], want[3], want[2], want[1], want[0]);
    end
  endtask

  function automatic exp_t ev(input int q, input bit en, input bit clr,
                              input bit t, input bit b, input bit d);
    logic [3:0] q4;
    q4 = q[3:0];
    return {q4, en, clr, t, b, d};
  endfunction

  task automatic tick(input string tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      check(tag, {cnt_q, cnt_en, cnt_clr, tc, busy, done}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic push_idle(input int q, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ev(q, 0, 0, 0, 0, 0));
  endtask

  task automatic push_clear(input int q);
    exp_q.push_back(ev(q, 0, 1, 0, 1, 0));
  endtask

  task automatic push_done(input int q, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ev(q, 0, 0, 0, 0, 1));
  endtask

  // RUN cycles k0..k0+n-1 of a continuous count with terminal t.
  task automatic push_run_cont(input int t, input int k0, input int n);
    int q;
    for (int k = k0; k < k0 + n; k++) begin
      q = k % (t + 1);
      if (q == t) exp_q.push_back(ev(q, 0, 1, 1, 1, 0));
      else        exp_q.push_back(ev(q, 1, 0, 0, 1, 0));
    end
  endtask

  task automatic do_start(input int t, input bit os, input string tag);
    term     = t[3:0];
    one_shot = os;
    start    = 1'b1;
    tick(tag);
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; pause = 1'b0;
    one_shot = 1'b0; term = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset state and idle behaviour.
    push_idle(0, 5);
    run("idle", 5);

    // Continuous term=5, then halt mid-count (q=2 -> frozen at 3).
    push_idle(0, 1);
    do_start(5, 0, "start5");
    push_clear(0);
    push_run_cont(5, 0, 14);
    run("cont5", 15);
    push_run_cont(5, 14, 1);
    halt = 1'b1; tick("halt5"); halt = 1'b0;
    push_idle(3, 2);
    run("halted5", 2);

    // One-shot term=3 with done held for 10 cycles.
    push_idle(3, 1);
    do_start(3, 1, "start_os3");
    push_clear(3);
    push_run_cont(3, 0, 3);
    exp_q.push_back(ev(3, 0, 0, 1, 1, 0));
    push_done(3, 10);
    run("os3", 15);

    // Restart from DONE: one-shot term=1.
    push_done(3, 1);
    do_start(1, 1, "start_os1");
    push_clear(3);
    exp_q.push_back(ev(0, 1, 0, 0, 1, 0));
    exp_q.push_back(ev(1, 0, 0, 1, 1, 0));
    push_done(1, 3);
    run("os1", 6);

    // term=0 continuous: tc and clr every RUN cycle.
    push_done(1, 1);
    do_start(0, 0, "start0");
    push_clear(1);
    push_run_cont(0, 0, 4);
    run("cont0", 5);

    // Restart from RUN with term=15: full period of 16, cleared at 15.
    push_run_cont(0, 4, 1);
    do_start(15, 0, "start15");
    push_clear(0);
    push_run_cont(15, 0, 34);
    run("cont15", 35);

    // Restart with term=7, then halt+start together: halt wins, Q frozen at 2.
    push_run_cont(15, 34, 1);
    do_start(7, 0, "start7");
    push_clear(3);
    push_run_cont(7, 0, 1);
    run("cont7", 2);
    push_run_cont(7, 1, 1);
    halt = 1'b1; start = 1'b1; term = 4'd7; tick("halt_start");
    halt = 1'b0; start = 1'b0;
    push_idle(2, 2);
    run("halted7", 2);

    // Fresh start counts from 0; reset at Q=4 returns to IDLE.
    push_idle(2, 1);
    do_start(7, 0, "restart7");
    push_clear(2);
    push_run_cont(7, 0, 4);
    run("run7", 5);
    push_run_cont(7, 4, 1);
    reset = 1'b1; tick("reset_mid"); reset = 1'b0;
    push_idle(0, 2);
    run("after_reset", 2);

    // Pause for 3 cycles at Q=4.
    push_idle(0, 1);
    do_start(7, 0, "start_p");
    push_clear(0);
    push_run_cont(7, 0, 4);
    run("run_p", 5);
`ifdef CNT_SEQ_PAUSE_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(4, 0, 0, 0, 1, 0));
    pause = 1'b1; run("pause", 3); pause = 1'b0;
    exp_q.push_back(ev(4, 0, 0, 0, 1, 0));
    push_run_cont(7, 4, 4);
    run("resume", 5);
`else
    push_run_cont(7, 4, 3);
    pause = 1'b1; run("pause_ignored", 3); pause = 1'b0;
    push_run_cont(7, 7, 3);
    run("resume", 3);
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: got %0d queued entries, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
